mem_access_unit: RTL and testbench

//   Data-memory access stage, directly downstream of the LOAD/STORE execute block.

---
 rtl/simple_processor_pkg.sv | 29 ++
 rtl/mem_timeout_cnt.sv | 36 +++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// simple_processor_pkg
//   Shared types and constants for the simple processor datapath.
//   DATA_WIDTH / ADDR_WIDTH : datapath width and register-index width
//   func_t                  : execute-stage function codes (LOAD/STORE used by memory stage)
//   mem_state_e             : state encoding of the data-memory access stage
//   MEM_TIMEOUT_DEF         : default memory-access timeout in cycles
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    LOAD  = 3'd2,
    STORE = 3'd3,
    NOP   = 3'd4
  } func_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } mem_state_e;

  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt
//   Cycle counter bounding how long a memory access may stay outstanding.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   clr_i      : return counter to zero (priority over en_i)
//   en_i       : count this cycle
//   expired_o  : counter has reached TIMEOUT_CYCLES-1 (the last allowed cycle)
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The FSM leaves ISSUE/WAIT_R the same cycle this is seen, so the
  // counter never has to saturate.
  assign expired_o = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Data-memory access stage behind the LOAD/STORE execute block. Takes one
//   request at a time, drives a valid/ready request to data memory, waits for
//   rvalid on loads and returns a one-cycle completion to writeback.
//   Ports:
//     clk_i, rst_i                  : clock, synchronous active-high reset
//     req_valid_i / req_ready_o     : request handshake from execute stage
//     func_i, addr_i, wdata_i       : function, byte address, store data
//     rd_addr_i                     : destination register, carried to rsp_rd_addr_o
//     dmem_valid_o / dmem_ready_i   : memory request handshake
//     dmem_we_o, dmem_addr_o,
//     dmem_wdata_o                  : latched request fields
//     dmem_rvalid_i, dmem_rdata_i   : memory read return
//     rsp_valid_o, rsp_data_o,
//     rsp_rd_addr_o, rsp_err_o      : completion to writeback
//     busy_o                        : unit is not idle (pipeline stalls)
module mem_access_unit
  import simple_processor_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  func_t                 func_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  dmem_valid_o,
  input  logic                  dmem_ready_i,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [ADDR_WIDTH-1:0] rsp_rd_addr_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  mem_state_e            r_state;
  mem_state_e            w_state_next;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic w_is_mem_op;
  logic w_misaligned;
  logic w_accept;
  logic w_capture;
  logic w_timeout;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_expired;

  assign w_is_mem_op  = (func_i == LOAD) || (func_i == STORE);
  assign w_misaligned = (addr_i[1:0] != 2'b00);

  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (w_cnt_clr),
    .en_i     (w_cnt_en),
    .expired_o(w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        // Non-memory functions are accepted (ready is high) but produce nothing.
        if (req_valid_i && w_is_mem_op) begin
          w_accept = 1'b1;
          if (w_misaligned) begin
            w_state_next = DONE;
          end else begin
            w_state_next = ISSUE;
            w_cnt_clr    = 1'b1;
          end
        end
      end
      ISSUE: begin
        w_cnt_en = 1'b1;
        if (dmem_ready_i) begin
          if (r_we) begin
            w_state_next = DONE;
          end else if (dmem_rvalid_i) begin
            // Memory returned data in the handshake cycle itself.
            w_capture    = 1'b1;
            w_state_next = DONE;
          end else if (w_expired) begin
            w_timeout    = 1'b1;
            w_state_next = DONE;
          end else begin
            w_state_next = WAIT_R;
          end
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = DONE;
        end
      end
      WAIT_R: begin
        w_cnt_en = 1'b1;
        if (dmem_rvalid_i) begin
          w_capture    = 1'b1;
          w_state_next = DONE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= (func_i == STORE);
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
      r_rd    <= rd_addr_i;
      r_rdata <= '0;
      r_err   <= w_misaligned;
    end else if (w_capture) begin
      r_rdata <= dmem_rdata_i;
    end else if (w_timeout) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end
  end

  assign req_ready_o   = (r_state == IDLE) && !rst_i;
  assign busy_o        = (r_state != IDLE);
  assign dmem_valid_o  = (r_state == ISSUE);
  assign dmem_we_o     = r_we;
  assign dmem_addr_o   = r_addr;
  assign dmem_wdata_o  = r_wdata;
  assign rsp_valid_o   = (r_state == DONE);
  assign rsp_data_o    = r_rdata;
  assign rsp_rd_addr_o = r_rd;
  assign rsp_err_o     = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit: reset, zero-wait load, stalled store,
//   misaligned access, timeout, reset during WAIT_R, back-to-back requests and
//   a non-memory function.
module tb_mem_access_unit;
  import simple_processor_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  func_t                 func;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  dmem_valid;
  logic                  dmem_ready;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_rvalid;
  logic [DATA_WIDTH-1:0] dmem_rdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_rd_addr;
  logic                  rsp_err;
  logic                  busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .func_i       (func),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rd_addr_i    (rd_addr),
    .dmem_valid_o (dmem_valid),
    .dmem_ready_i (dmem_ready),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rsp_rd_addr_o(rsp_rd_addr),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input func_t f, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd);
    req_valid = 1'b1;
    func      = f;
    addr      = a;
    wdata     = d;
    rd_addr   = rd;
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    func        = NOP;
    addr        = '0;
    wdata       = '0;
    rd_addr     = '0;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;

    // Reset
    tick();
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dmem_valid", {31'd0, dmem_valid}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    $display("txn reset done");

    // Zero-wait LOAD: handshake next cycle, data the cycle after
    set_req(LOAD, 32'h10, 32'h0, 5'd5);
    dmem_ready = 1'b1;
    tick();                                   // edge N: accept
    req_valid = 1'b0;
    chk("ld_dmem_valid", {31'd0, dmem_valid}, 32'd1);
    chk("ld_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("ld_dmem_addr", dmem_addr, 32'h10);
    chk("ld_busy", {31'd0, busy}, 32'd1);
    chk("ld_req_ready", {31'd0, req_ready}, 32'd0);
    tick();                                   // edge N+1: handshake
    chk("ld_n1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ld_n1_dmem_valid", {31'd0, dmem_valid}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    tick();                                   // edge N+2: data captured
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    chk("ld_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ld_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("ld_rsp_rd", {27'd0, rsp_rd_addr}, 32'd5);
    chk("ld_rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();
    chk("ld_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    chk("ld_idle_ready", {31'd0, req_ready}, 32'd1);
    $display("txn LOAD addr=0x10 rd=5 data=0x%0h err=%0d", 32'hDEADBEEF, 0);

    // STORE with ready held low for three cycles; stray rvalid must be ignored
    dmem_ready = 1'b0;
    set_req(STORE, 32'h20, 32'h12345678, 5'd9);
    tick();
    req_valid   = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      chk("st_dmem_valid", {31'd0, dmem_valid}, 32'd1);
      chk("st_dmem_addr", dmem_addr, 32'h20);
      chk("st_dmem_wdata", dmem_wdata, 32'h12345678);
      chk("st_dmem_we", {31'd0, dmem_we}, 32'd1);
      if (i < 2) tick();
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    chk("st_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("st_rsp_data", rsp_data, 32'd0);
    chk("st_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("st_rsp_rd", {27'd0, rsp_rd_addr}, 32'd9);
    tick();
    $display("txn STORE addr=0x20 wdata=0x12345678 err=0");

    // Misaligned LOAD: straight to DONE with error, memory untouched
    set_req(LOAD, 32'h13, 32'h0, 5'd2);
    tick();
    req_valid = 1'b0;
    chk("mis_dmem_valid", {31'd0, dmem_valid}, 32'd0);
    chk("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mis_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("mis_rsp_data", rsp_data, 32'd0);
    tick();
    $display("txn LOAD addr=0x13 misaligned err=1");

    // Timeout: ready never asserted
    set_req(LOAD, 32'h40, 32'h0, 5'd1);
    tick();                                   // enter ISSUE
    req_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("to_rsp_valid_%0d", i), {31'd0, rsp_valid}, (i == 16) ? 32'd1 : 32'd0);
    end
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_data", rsp_data, 32'd0);
    chk("to_dmem_valid", {31'd0, dmem_valid}, 32'd0);
    tick();
    $display("txn LOAD addr=0x40 timeout err=1");

    // Reset while in WAIT_R, then the late rvalid
    set_req(LOAD, 32'h80, 32'h0, 5'd4);
    dmem_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    dmem_ready = 1'b0;
    chk("rw_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_dmem_valid", {31'd0, dmem_valid}, 32'd0);
    chk("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0BADF00D;
    tick();
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rw_ready", {31'd0, req_ready}, 32'd1);
      chk("rw_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    $display("txn LOAD addr=0x80 abandoned by reset");

    // Back-to-back with req_valid held
    dmem_ready = 1'b1;
    set_req(LOAD, 32'h100, 32'h0, 5'd3);
    tick();
    set_req(STORE, 32'h104, 32'hCAFE, 5'd7);
    chk("bb_busy_issue", {31'd0, busy}, 32'd1);
    chk("bb_ready_issue", {31'd0, req_ready}, 32'd0);
    tick();
    chk("bb_ready_wait", {31'd0, req_ready}, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h55;
    tick();
    dmem_rvalid = 1'b0;
    chk("bb_ld_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bb_ld_rsp_data", rsp_data, 32'h55);
    chk("bb_ld_rsp_rd", {27'd0, rsp_rd_addr}, 32'd3);
    chk("bb_ready_done", {31'd0, req_ready}, 32'd0);
    chk("bb_busy_done", {31'd0, busy}, 32'd1);
    tick();
    chk("bb_ready_idle", {31'd0, req_ready}, 32'd1);
    chk("bb_busy_idle", {31'd0, busy}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("bb_st_we", {31'd0, dmem_we}, 32'd1);
    chk("bb_st_addr", dmem_addr, 32'h104);
    chk("bb_st_wdata", dmem_wdata, 32'hCAFE);
    tick();
    chk("bb_st_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bb_st_rsp_rd", {27'd0, rsp_rd_addr}, 32'd7);
    chk("bb_st_rsp_data", rsp_data, 32'd0);
    chk("bb_st_rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();
    dmem_ready = 1'b0;
    $display("txn back-to-back LOAD 0x100 / STORE 0x104");

    // Non-memory function is consumed silently
    set_req(ADD, 32'h200, 32'h1, 5'd6);
    tick();
    req_valid = 1'b0;
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_dmem_valid", {31'd0, dmem_valid}, 32'd0);
    tick();
    chk("nop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    $display("txn ADD dropped");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
